// File: rtl/rx_frame_reader.sv
// Read-side controller for the receive frame FIFO: turns one stored frame into a
// valid/ready byte stream with first/last markers, with drop and rewind support.
module rx_frame_reader #(
    parameter int FIFO_DEPTH = 12,
    parameter int MAX_FRAME  = 2047
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_available,
    input  logic [7:0]            fifo_data,
    input  logic                  fifo_start,
    input  logic                  fifo_end,
    input  logic [FIFO_DEPTH-1:0] fifo_address,
    output logic                  fifo_enable,
    output logic                  fifo_reset,
    output logic [FIFO_DEPTH-1:0] fifo_reset_address,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    input  logic                  frame_drop,
    input  logic                  frame_rewind,
    output logic                  frame_done,
    output logic                  frame_dropped,
    output logic [15:0]           frame_length,
    output logic [15:0]           frame_count,
    output logic                  sync_error
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        SKIP_WAIT,
        SKIP_POP,
        REWIND
    } state_t;

    state_t                state, state_nx;
    logic [FIFO_DEPTH-1:0] start_addr, start_nx;
    logic [7:0]            data_nx;
    logic                  valid_nx, first_nx, last_nx, dropped_nx;
    logic [15:0]           length_nx, count_nx;
    logic                  enable_c, rewind_c, done_c, sync_c;
    logic                  handshake;

    assign handshake = m_valid && m_ready;

    always_comb begin
        state_nx   = state;
        start_nx   = start_addr;
        data_nx    = m_data;
        valid_nx   = m_valid;
        first_nx   = m_first;
        last_nx    = m_last;
        dropped_nx = frame_dropped;
        length_nx  = frame_length;
        count_nx   = frame_count;
        enable_c   = 1'b0;
        rewind_c   = 1'b0;
        done_c     = 1'b0;
        sync_c     = 1'b0;

        case (state)
            IDLE: begin
                if (data_available) begin
                    start_nx   = fifo_address;
                    length_nx  = '0;
                    dropped_nx = 1'b0;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                // Framing checks win over consumer requests: a bad frame is always flushed.
                if ((frame_length == '0) && !fifo_start) begin
                    sync_c     = 1'b1;
                    dropped_nx = 1'b1;
                    state_nx   = SKIP_POP;
                end else if (frame_length >= 16'(MAX_FRAME)) begin
                    sync_c     = 1'b1;
                    dropped_nx = 1'b1;
                    state_nx   = SKIP_POP;
                end else if (frame_drop) begin
                    dropped_nx = 1'b1;
                    state_nx   = SKIP_POP;
                end else if (frame_rewind) begin
                    rewind_c   = 1'b1;
                    length_nx  = '0;
                    state_nx   = REWIND;
                end else begin
                    data_nx    = fifo_data;
                    first_nx   = fifo_start;
                    last_nx    = fifo_end;
                    valid_nx   = 1'b1;
                    state_nx   = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    valid_nx  = 1'b0;
                    length_nx = frame_length + 16'd1;
                    if (m_last) begin
                        enable_c = 1'b1;
                        done_c   = 1'b1;
                        count_nx = frame_count + 16'd1;
                        state_nx = IDLE;
                    end else if (frame_drop) begin
                        enable_c   = 1'b1;
                        dropped_nx = 1'b1;
                        state_nx   = SKIP_POP;
                    end else if (frame_rewind) begin
                        // The pointer reload supersedes the pop of the byte just taken.
                        rewind_c  = 1'b1;
                        length_nx = '0;
                        state_nx  = REWIND;
                    end else begin
                        enable_c = 1'b1;
                        state_nx = LOAD;
                    end
                end else if (frame_drop) begin
                    valid_nx   = 1'b0;
                    dropped_nx = 1'b1;
                    state_nx   = SKIP_POP;
                end else if (frame_rewind) begin
                    valid_nx  = 1'b0;
                    rewind_c  = 1'b1;
                    length_nx = '0;
                    state_nx  = REWIND;
                end
            end
            SKIP_POP: begin
                enable_c = 1'b1;
                if (fifo_end) begin
                    done_c   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = SKIP_WAIT;
                end
            end
            SKIP_WAIT: state_nx = SKIP_POP;
            REWIND:    state_nx = LOAD;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            start_addr    <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            m_first       <= 1'b0;
            m_last        <= 1'b0;
            frame_dropped <= 1'b0;
            frame_length  <= '0;
            frame_count   <= '0;
        end else begin
            state         <= state_nx;
            start_addr    <= start_nx;
            m_data        <= data_nx;
            m_valid       <= valid_nx;
            m_first       <= first_nx;
            m_last        <= last_nx;
            frame_dropped <= dropped_nx;
            frame_length  <= length_nx;
            frame_count   <= count_nx;
        end
    end

    // Pulses are suppressed while reset is held so the FIFO pointer stays put.
    assign fifo_enable        = enable_c && !reset;
    assign fifo_reset         = rewind_c && !reset;
    assign frame_done         = done_c && !reset;
    assign sync_error         = sync_c && !reset;
    assign fifo_reset_address = start_addr;

endmodule

// File: tb/tb_rx_frame_reader.sv
// Bench for rx_frame_reader: behavioural FIFO, table-driven frames, hand-written
// rewind/sync/reset/overflow sequences and randomized frames against a stream model.
module tb_rx_frame_reader;

    localparam int MAXF = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        data_available;
    logic [7:0]  fifo_data;
    logic        fifo_start, fifo_end;
    logic [11:0] fifo_address;
    logic        fifo_enable, fifo_reset;
    logic [11:0] fifo_reset_address;
    logic [7:0]  m_data;
    logic        m_valid, m_first, m_last;
    logic        m_ready = 1'b0;
    logic        frame_drop = 1'b0;
    logic        frame_rewind = 1'b0;
    logic        frame_done, frame_dropped, sync_error;
    logic [15:0] frame_length, frame_count;

    rx_frame_reader #(.FIFO_DEPTH(12), .MAX_FRAME(MAXF)) dut (
        .clock(clock), .reset(reset), .data_available(data_available),
        .fifo_data(fifo_data), .fifo_start(fifo_start), .fifo_end(fifo_end),
        .fifo_address(fifo_address), .fifo_enable(fifo_enable), .fifo_reset(fifo_reset),
        .fifo_reset_address(fifo_reset_address), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_first(m_first), .m_last(m_last), .frame_drop(frame_drop),
        .frame_rewind(frame_rewind), .frame_done(frame_done), .frame_dropped(frame_dropped),
        .frame_length(frame_length), .frame_count(frame_count), .sync_error(sync_error)
    );

    always #5 clock = ~clock;

    // Behavioural FIFO read side: words are {start, end, data}
    logic [9:0]  mem [0:4095];
    logic [11:0] rd_addr = '0;
    logic [11:0] wr_ptr = '0;
    logic        set_ptr = 1'b0;
    logic [11:0] set_val = '0;
    logic        avail_en = 1'b1;

    always @(posedge clock) begin
        if (set_ptr) rd_addr <= set_val;
        else if (fifo_reset) rd_addr <= fifo_reset_address;
        else if (fifo_enable) rd_addr <= rd_addr + 12'd1;
    end

    assign fifo_data      = mem[rd_addr][7:0];
    assign fifo_start     = mem[rd_addr][9];
    assign fifo_end       = mem[rd_addr][8];
    assign fifo_address   = rd_addr;
    assign data_available = avail_en && (rd_addr != wr_ptr);

    // Monitor: sampled on the falling edge
    int          pop_cnt = 0, rst_cnt = 0, done_cnt = 0, sync_cnt = 0, valid_cycles = 0, viol_cnt = 0;
    logic        done_dropped_last = 1'b0;
    logic [11:0] rst_addr_last = '0;
    logic [9:0]  acc [$];
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;

    always @(negedge clock) begin
        if (!reset) begin
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) acc.push_back({m_first, m_last, m_data});
            if (fifo_enable) pop_cnt++;
            if (fifo_reset) begin
                rst_cnt++;
                rst_addr_last = fifo_reset_address;
                if (frame_done || sync_error) viol_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                done_dropped_last = frame_dropped;
            end
            if (sync_error) sync_cnt++;
            if (prev_hold && (!m_valid || m_data != prev_data)) viol_cnt++;
            prev_hold = m_valid && !m_ready && !frame_drop && !frame_rewind;
            prev_data = m_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    int compared = 0, mismatched = 0;
    logic [7:0] frame_bytes [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input int len, input bit good_start, input bit rnd);
        frame_bytes.delete();
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : 8'(8'hAA + 17 * i);
            frame_bytes.push_back(b);
            mem[wr_ptr + 12'(i)] = {(good_start && i == 0), (i == len - 1), b};
        end
        wr_ptr = wr_ptr + 12'(len);
    endtask

    task automatic check_stream(input string name, input int mark, input int n);
        for (int j = 0; j < n; j++) begin
            if (mark + j < acc.size())
                check(name, acc[mark + j], {(j == 0), (j == frame_bytes.size() - 1), frame_bytes[j]});
            else
                check({name, "_missing"}, 0, 1);
        end
    endtask

    task automatic drain(input int rdy_pct, input int drop_den, output bit drop_seen);
        int base_done;
        base_done = done_cnt;
        drop_seen = 1'b0;
        for (int c = 0; c < 400 && done_cnt == base_done; c++) begin
            m_ready = ($urandom_range(0, 99) < rdy_pct);
            frame_drop = 1'b0;
            if (drop_den > 0) frame_drop = ($urandom_range(0, drop_den - 1) == 0);
            if (frame_drop) drop_seen = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        frame_drop = 1'b0;
        check("frame_done_seen", done_cnt - base_done, 1);
    endtask

    typedef struct {
        int len;
        int stall_at;
        int stall_cycles;
        int drop_after;
        int exp_len;
        bit exp_dropped;
        int exp_pops;
        int exp_inc;
    } vec_t;

    vec_t vecs [8];

    task automatic run_frame(input vec_t v);
        int base_pop, base_acc, base_done, base_sync, k;
        int stall_left, stall_pop0, stall_pop1;
        bit stall_started, stall_recorded;
        logic [15:0] base_cnt;
        base_pop = pop_cnt; base_acc = acc.size(); base_done = done_cnt;
        base_sync = sync_cnt; base_cnt = frame_count;
        stall_left = v.stall_cycles; stall_pop0 = 0; stall_pop1 = 0;
        stall_started = 1'b0; stall_recorded = 1'b0;
        push_frame(v.len, 1'b1, 1'b0);
        for (int c = 0; c < 300 && done_cnt == base_done; c++) begin
            k = acc.size() - base_acc;
            if (stall_started && stall_left == 0 && !stall_recorded) begin
                stall_pop1 = pop_cnt;
                stall_recorded = 1'b1;
            end
            m_ready = 1'b1;
            frame_drop = 1'b0;
            if (v.drop_after >= 0 && k == v.drop_after) begin
                m_ready = 1'b0;
                frame_drop = 1'b1;
            end else if (k == v.stall_at && stall_left > 0 && m_valid) begin
                if (!stall_started) stall_pop0 = pop_cnt;
                stall_started = 1'b1;
                m_ready = 1'b0;
                stall_left--;
            end
            tick();
        end
        m_ready = 1'b0;
        frame_drop = 1'b0;
        k = acc.size() - base_acc;
        check("tbl_done_seen", done_cnt - base_done, 1);
        check("tbl_done_dropped", done_dropped_last, v.exp_dropped);
        check("tbl_frame_dropped", frame_dropped, v.exp_dropped);
        check("tbl_frame_length", frame_length, 16'(v.exp_len));
        check("tbl_accepted", k, v.exp_len);
        check("tbl_frame_count", 16'(frame_count - base_cnt), 16'(v.exp_inc));
        check("tbl_pops", pop_cnt - base_pop, v.exp_pops);
        check("tbl_sync", sync_cnt - base_sync, 0);
        check("tbl_consumed", rd_addr, wr_ptr);
        check_stream("tbl_byte", base_acc, (k < v.exp_len) ? k : v.exp_len);
        if (v.stall_cycles > 0) begin
            check("stall_done", stall_recorded, 1);
            check("stall_no_pop", stall_pop1 - stall_pop0, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_pop, base_acc, base_sync, base_rst, base_valid, k, mark, delivered;
        logic [15:0] base_cnt;
        logic [11:0] addr_before;
        bit drop_seen;

        vecs[0] = '{3, -1, 0, -1, 3, 1'b0, 3, 1};
        vecs[1] = '{3,  1, 5, -1, 3, 1'b0, 3, 1};
        vecs[2] = '{6, -1, 0,  1, 1, 1'b1, 6, 0};
        vecs[3] = '{1, -1, 0, -1, 1, 1'b0, 1, 1};
        vecs[4] = '{6, -1, 0,  5, 5, 1'b1, 6, 0};
        vecs[5] = '{4, -1, 0,  0, 0, 1'b1, 4, 0};
        vecs[6] = '{8, -1, 0, -1, 8, 1'b0, 8, 1};
        vecs[7] = '{5,  3, 2, -1, 5, 1'b0, 5, 1};

        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {fifo_enable, fifo_reset, fifo_reset_address, m_data, m_valid,
                                m_first, m_last, frame_done, frame_dropped, frame_length,
                                frame_count, sync_error}, 64'd0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_frame(vecs[i]);

        // Rewind on a frame that wraps the address space
        avail_en = 1'b0;
        set_val = 12'hFFE; set_ptr = 1'b1;
        tick();
        set_ptr = 1'b0;
        wr_ptr = 12'hFFE;
        avail_en = 1'b1;
        base_pop = pop_cnt; base_acc = acc.size(); base_rst = rst_cnt; base_cnt = frame_count;
        push_frame(5, 1'b1, 1'b0);
        for (int c = 0; c < 100 && rst_cnt == base_rst; c++) begin
            k = acc.size() - base_acc;
            m_ready = (k < 2);
            frame_rewind = (k >= 2);
            tick();
        end
        frame_rewind = 1'b0;
        m_ready = 1'b0;
        check("rew_pulses", rst_cnt - base_rst, 1);
        check("rew_address", rst_addr_last, 12'hFFE);
        check("rew_accepted_before", acc.size() - base_acc, 2);
        check("rew_length_cleared", frame_length, 16'd0);
        check("rew_pointer", rd_addr, 12'hFFE);
        mark = acc.size();
        drain(100, 0, drop_seen);
        check_stream("rew_replay", mark, 5);
        check("rew_final_length", frame_length, 16'd5);
        check("rew_count", 16'(frame_count - base_cnt), 16'd1);
        check("rew_pops", pop_cnt - base_pop, 7);
        check("rew_rst_total", rst_cnt - base_rst, 1);
        check("rew_consumed", rd_addr, 12'h003);

        // Missing start flag: flushed through the sync error path
        base_pop = pop_cnt; base_acc = acc.size(); base_sync = sync_cnt;
        base_valid = valid_cycles; base_cnt = frame_count;
        push_frame(4, 1'b0, 1'b0);
        drain(100, 0, drop_seen);
        check("sync_pulses", sync_cnt - base_sync, 1);
        check("sync_no_valid", valid_cycles - base_valid, 0);
        check("sync_pops", pop_cnt - base_pop, 4);
        check("sync_done_dropped", done_dropped_last, 1);
        check("sync_count", 16'(frame_count - base_cnt), 16'd0);
        check("sync_consumed", rd_addr, wr_ptr);

        // Length overflow: frame longer than MAXF
        base_pop = pop_cnt; base_acc = acc.size(); base_sync = sync_cnt; base_cnt = frame_count;
        push_frame(11, 1'b1, 1'b0);
        drain(100, 0, drop_seen);
        check("ovf_accepted", acc.size() - base_acc, MAXF);
        check("ovf_length", frame_length, 16'(MAXF));
        check("ovf_sync", sync_cnt - base_sync, 1);
        check("ovf_pops", pop_cnt - base_pop, 11);
        check("ovf_dropped", done_dropped_last, 1);
        check("ovf_count", 16'(frame_count - base_cnt), 16'd0);
        check_stream("ovf_byte", base_acc, MAXF);

        // Synchronous reset while a byte is presented
        base_acc = acc.size();
        push_frame(4, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !((acc.size() - base_acc) == 1 && m_valid); c++) begin
            m_ready = ((acc.size() - base_acc) == 0);
            tick();
        end
        m_ready = 1'b0;
        check("rst_presenting", m_valid, 1);
        addr_before = rd_addr;
        reset = 1'b1;
        tick();
        check("rst_mid_outputs", {fifo_enable, fifo_reset, fifo_reset_address, m_data, m_valid,
                                  m_first, m_last, frame_done, frame_dropped, frame_length,
                                  frame_count, sync_error}, 64'd0);
        check("rst_pointer", rd_addr, addr_before);
        reset = 1'b0;
        base_pop = pop_cnt; base_sync = sync_cnt;
        drain(100, 0, drop_seen);
        check("rst_resync_sync", sync_cnt - base_sync, 1);
        check("rst_resync_pops", pop_cnt - base_pop, 3);
        check("rst_resync_dropped", done_dropped_last, 1);
        run_frame(vecs[0]);
        check("rst_clean_count", frame_count, 16'd1);

        // Randomized frames with random backpressure and drops
        base_cnt = frame_count;
        delivered = 0;
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, 10);
            base_acc = acc.size(); base_sync = sync_cnt;
            push_frame(len, 1'b1, 1'b1);
            drain(70, 30, drop_seen);
            k = acc.size() - base_acc;
            if (!drop_seen) check("rnd_dropped", done_dropped_last, (len > MAXF));
            if (done_dropped_last) begin
                check("rnd_drop_cause", (drop_seen || len > MAXF), 1);
                check("rnd_drop_short", (k < len), 1);
            end else begin
                check("rnd_full", k, len);
                delivered++;
            end
            check("rnd_kmax", (k <= MAXF), 1);
            check("rnd_length", frame_length, 16'(k));
            if (len <= MAXF) check("rnd_sync", sync_cnt - base_sync, 0);
            else if (!drop_seen) check("rnd_sync", sync_cnt - base_sync, 1);
            check("rnd_consumed", rd_addr, wr_ptr);
            check_stream("rnd_byte", base_acc, k);
            tick();
        end
        check("rnd_count", 16'(frame_count - base_cnt), 16'(delivered));
        check("invariants", viol_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
